// File: rtl/uart_param.sv
// uart_param: full-duplex RS232 UART with a generic 16x baud generator,
// configurable frame format (5..8 data bits, none/even/odd parity, 1 or 2
// stop bits), TX/RX FIFOs with a push/ack host handshake, and sticky line
// error flags.

// Synchronous FIFO with first-word fall-through head and extra-MSB pointers.
module uart_param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status flags, accepted push/pop strobes and the fall-through head word.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_ok_s  = pop && !empty;
        // A pop frees the slot being written, so a full FIFO may push and pop together.
        push_ok_s = push && (!full || pop_ok_s);
        head      = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Storage array; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end
endmodule

module uart_param #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 write_tx_data,
    output logic                 tx_buffer_full,
    output logic                 tx_busy,
    output logic                 rs232_tx,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] rx_data_out,
    input  logic                 read_rx_data_ack,
    output logic                 rx_data_present,
    output logic                 rx_buffer_full,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error,
    input  logic                 clear_errors
);
    localparam int DIV = CLK_FREQ / (16 * BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    DB_LAST  = 4'(DATA_BITS - 1);
    localparam logic [4:0]    TX_STOP_LAST = 5'(STOP_BITS * 16 - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // Parity bit that accompanies a data word: even = XOR, odd = inverted XOR.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        parity_bit = (^d) ^ (PARITY == 2);
    endfunction

    // Baud generator.
    logic [CW-1:0] baud_cnt_r;
    logic          tick_s;

    // TX path.
    tx_state_t            tx_state_r;
    logic [4:0]           tx_tick_r;
    logic [3:0]           tx_bit_r;
    logic [DATA_BITS-1:0] tx_shift_r;
    logic                 tx_par_r;
    logic                 rs232_tx_r;
    logic [DATA_BITS-1:0] tx_head_s;
    logic                 tx_full_s;
    logic                 tx_empty_s;
    logic                 tx_pop_s;

    // RX path.
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    rx_state_t            rx_state_r;
    logic [3:0]           rx_tick_r;
    logic [3:0]           rx_bit_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_par_r;
    logic                 rx_push_r;
    logic [DATA_BITS-1:0] rx_word_r;
    logic                 par_set_r;
    logic                 frm_set_r;
    logic                 ovr_set_r;
    logic [DATA_BITS-1:0] rx_head_s;
    logic                 rx_full_s;
    logic                 rx_empty_s;

    // Sticky flags.
    logic parity_error_r;
    logic framing_error_r;
    logic overrun_error_r;

    uart_param_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (write_tx_data),
        .push_data (tx_data_in),
        .pop       (tx_pop_s),
        .head      (tx_head_s),
        .full      (tx_full_s),
        .empty     (tx_empty_s)
    );

    uart_param_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push_r),
        .push_data (rx_word_r),
        .pop       (read_rx_data_ack),
        .head      (rx_head_s),
        .full      (rx_full_s),
        .empty     (rx_empty_s)
    );

    assign tick_s = (baud_cnt_r == DIV_LAST);

    // 16x oversampling tick: count 0..DIV-1, pulse on the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt_r <= '0;
        end else if (tick_s) begin
            baud_cnt_r <= '0;
        end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
        end
    end

    // The TX FIFO head is taken when idle, or at the end of STOP for back-to-back frames.
    always_comb begin
        tx_pop_s = 1'b0;
        if (tick_s && !tx_empty_s) begin
            if (tx_state_r == TX_IDLE) begin
                tx_pop_s = 1'b1;
            end else if ((tx_state_r == TX_STOP) && (tx_tick_r == TX_STOP_LAST)) begin
                tx_pop_s = 1'b1;
            end else begin
                tx_pop_s = 1'b0;
            end
        end else begin
            tx_pop_s = 1'b0;
        end
    end

    // Transmit FSM; every bit period is 16 ticks and the line level is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
            tx_tick_r  <= 5'd0;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= '0;
            tx_par_r   <= 1'b0;
            rs232_tx_r <= 1'b1;
        end else if (tick_s) begin
            case (tx_state_r)
                TX_IDLE: begin
                    if (tx_pop_s) begin
                        tx_shift_r <= tx_head_s;
                        tx_par_r   <= parity_bit(tx_head_s);
                        tx_tick_r  <= 5'd0;
                        rs232_tx_r <= 1'b0;
                        tx_state_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tick_r == 5'd15) begin
                        tx_tick_r  <= 5'd0;
                        tx_bit_r   <= 4'd0;
                        rs232_tx_r <= tx_shift_r[0];
                        tx_state_r <= TX_DATA;
                    end else begin
                        tx_tick_r <= tx_tick_r + 5'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_tick_r == 5'd15) begin
                        tx_tick_r <= 5'd0;
                        if (tx_bit_r == DB_LAST) begin
                            if (PARITY != 0) begin
                                rs232_tx_r <= tx_par_r;
                                tx_state_r <= TX_PARITY;
                            end else begin
                                rs232_tx_r <= 1'b1;
                                tx_state_r <= TX_STOP;
                            end
                        end else begin
                            tx_bit_r   <= tx_bit_r + 4'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                            rs232_tx_r <= tx_shift_r[1];
                        end
                    end else begin
                        tx_tick_r <= tx_tick_r + 5'd1;
                    end
                end
                TX_PARITY: begin
                    if (tx_tick_r == 5'd15) begin
                        tx_tick_r  <= 5'd0;
                        rs232_tx_r <= 1'b1;
                        tx_state_r <= TX_STOP;
                    end else begin
                        tx_tick_r <= tx_tick_r + 5'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_tick_r == TX_STOP_LAST) begin
                        tx_tick_r <= 5'd0;
                        if (tx_pop_s) begin
                            tx_shift_r <= tx_head_s;
                            tx_par_r   <= parity_bit(tx_head_s);
                            rs232_tx_r <= 1'b0;
                            tx_state_r <= TX_START;
                        end else begin
                            rs232_tx_r <= 1'b1;
                            tx_state_r <= TX_IDLE;
                        end
                    end else begin
                        tx_tick_r <= tx_tick_r + 5'd1;
                    end
                end
                default: begin
                    tx_tick_r  <= 5'd0;
                    rs232_tx_r <= 1'b1;
                    tx_state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input (idles high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rs232_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM; samples mid-bit and raises one-cycle push/error strobes at the stop sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
            rx_tick_r  <= 4'd0;
            rx_bit_r   <= 4'd0;
            rx_shift_r <= '0;
            rx_par_r   <= 1'b0;
            rx_push_r  <= 1'b0;
            rx_word_r  <= '0;
            par_set_r  <= 1'b0;
            frm_set_r  <= 1'b0;
            ovr_set_r  <= 1'b0;
        end else begin
            rx_push_r <= 1'b0;
            par_set_r <= 1'b0;
            frm_set_r <= 1'b0;
            ovr_set_r <= 1'b0;
            if (tick_s) begin
                case (rx_state_r)
                    RX_IDLE: begin
                        if (!rx_sync_r) begin
                            rx_tick_r  <= 4'd0;
                            rx_state_r <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (rx_tick_r == 4'd7) begin
                            rx_tick_r <= 4'd0;
                            rx_bit_r  <= 4'd0;
                            // A line that is high again at mid-start was only a glitch.
                            if (rx_sync_r) begin
                                rx_state_r <= RX_IDLE;
                            end else begin
                                rx_state_r <= RX_DATA;
                            end
                        end else begin
                            rx_tick_r <= rx_tick_r + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_tick_r == 4'd15) begin
                            rx_tick_r  <= 4'd0;
                            rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_BITS-1:1]};
                            if (rx_bit_r == DB_LAST) begin
                                if (PARITY != 0) begin
                                    rx_state_r <= RX_PARITY;
                                end else begin
                                    rx_state_r <= RX_STOP;
                                end
                            end else begin
                                rx_bit_r <= rx_bit_r + 4'd1;
                            end
                        end else begin
                            rx_tick_r <= rx_tick_r + 4'd1;
                        end
                    end
                    RX_PARITY: begin
                        if (rx_tick_r == 4'd15) begin
                            rx_tick_r  <= 4'd0;
                            rx_par_r   <= rx_sync_r;
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_tick_r <= rx_tick_r + 4'd1;
                        end
                    end
                    RX_STOP: begin
                        if (rx_tick_r == 4'd15) begin
                            rx_tick_r  <= 4'd0;
                            frm_set_r  <= !rx_sync_r;
                            par_set_r  <= (PARITY != 0) && (rx_par_r != parity_bit(rx_shift_r));
                            if (rx_full_s) begin
                                ovr_set_r <= 1'b1;
                            end else begin
                                rx_push_r <= 1'b1;
                                rx_word_r <= rx_shift_r;
                            end
                            // Back to idle at mid-stop so a following start edge is not missed.
                            rx_state_r <= RX_IDLE;
                        end else begin
                            rx_tick_r <= rx_tick_r + 4'd1;
                        end
                    end
                    default: begin
                        rx_tick_r  <= 4'd0;
                        rx_state_r <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky error flags; a new error event overrides a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_error_r  <= 1'b0;
            framing_error_r <= 1'b0;
            overrun_error_r <= 1'b0;
        end else begin
            parity_error_r  <= (parity_error_r  && !clear_errors) || par_set_r;
            framing_error_r <= (framing_error_r && !clear_errors) || frm_set_r;
            overrun_error_r <= (overrun_error_r && !clear_errors) || ovr_set_r;
        end
    end

    assign rs232_tx        = rs232_tx_r;
    assign tx_buffer_full  = tx_full_s;
    assign tx_busy         = !tx_empty_s || (tx_state_r != TX_IDLE);
    assign rx_data_out     = rx_head_s;
    assign rx_data_present = !rx_empty_s;
    assign rx_buffer_full  = rx_full_s;
    assign parity_error    = parity_error_r;
    assign framing_error   = framing_error_r;
    assign overrun_error   = overrun_error_r;
endmodule
